// File: rtl/ws2812_pkg.sv
// Shared types and default 12 MHz timing for the WS2812 output stage.
package ws2812_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HIGH  = 2'd1,
    LOW   = 2'd2,
    LATCH = 2'd3
  } state_t;

  // Default bit/latch timing in clk cycles at 12 MHz
  localparam int unsigned T0H_DEF          = 5;
  localparam int unsigned T0L_DEF          = 10;
  localparam int unsigned T1H_DEF          = 10;
  localparam int unsigned T1L_DEF          = 5;
  localparam int unsigned RESET_CYCLES_DEF = 3600;

  localparam int unsigned PIXEL_W = 24;
  localparam int unsigned IDX_W   = $clog2(PIXEL_W);

  // GRB field offsets within a pixel word
  localparam int unsigned G_LSB = 16;
  localparam int unsigned R_LSB = 8;
  localparam int unsigned B_LSB = 0;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ws2812_bit_timer.sv
// Loadable down-counter timing the HIGH, LOW and LATCH intervals.
module ws2812_bit_timer #(
  parameter int unsigned CNT_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done_c,
  output logic             near_c
);

  logic [CNT_W-1:0] count;

  // Holds at zero once expired so done_c stays asserted until the next load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

  assign done_c = (count == '0);
  assign near_c = (count == CNT_W'(1));

endmodule

// File: rtl/ws2812_serializer.sv
// WS2812 NRZ serializer: accepts 24-bit GRB words and drives the data pin.
// Define WS2812_INVERT_EN to drive an inverted pin for an inverting level shifter.
module ws2812_serializer
  import ws2812_pkg::*;
#(
  parameter int unsigned T0H          = T0H_DEF,
  parameter int unsigned T0L          = T0L_DEF,
  parameter int unsigned T1H          = T1H_DEF,
  parameter int unsigned T1L          = T1L_DEF,
  parameter int unsigned RESET_CYCLES = RESET_CYCLES_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PIXEL_W-1:0] in_grb,
  input  logic               in_last,
  output logic               dout,
  output logic               busy,
  output logic               frame_done
);

  localparam int unsigned MAX_T = max_u(max_u(max_u(T0H, T0L), max_u(T1H, T1L)), RESET_CYCLES);
  localparam int unsigned CNT_W = $clog2(MAX_T + 1);
  localparam int unsigned MSB   = PIXEL_W - 1;

`ifdef WS2812_INVERT_EN
  localparam logic ACTIVE_LVL = 1'b0;
`else
  localparam logic ACTIVE_LVL = 1'b1;
`endif

  if (T0H == 0 || T0L == 0 || T1H == 0 || T1L == 0 || RESET_CYCLES == 0) begin : g_cfg_err
    $error("ws2812_serializer: every timing parameter must be >= 1");
  end

  state_t             state;
  logic [PIXEL_W-1:0] sr;
  logic [IDX_W-1:0]   bit_idx;
  logic               last;

  logic               accept_c;
  logic               load_c;
  logic [CNT_W-1:0]   load_val_c;
  logic               tmr_done_c;
  logic               tmr_near_c;

  function automatic logic [CNT_W-1:0] high_len(input logic b);
    return b ? CNT_W'(T1H - 1) : CNT_W'(T0H - 1);
  endfunction

  function automatic logic [CNT_W-1:0] low_len(input logic b);
    return b ? CNT_W'(T1L - 1) : CNT_W'(T0L - 1);
  endfunction

  // Timer reload at every interval boundary
  always_comb begin
    accept_c   = in_valid && in_ready;
    load_c     = 1'b0;
    load_val_c = '0;
    case (state)
      IDLE: begin
        if (accept_c) begin
          load_c     = 1'b1;
          load_val_c = high_len(in_grb[MSB]);
        end
      end
      HIGH: begin
        if (tmr_done_c) begin
          load_c     = 1'b1;
          load_val_c = low_len(sr[MSB]);
        end
      end
      LOW: begin
        if (tmr_done_c) begin
          if (bit_idx != '0) begin
            load_c     = 1'b1;
            load_val_c = high_len(sr[MSB-1]);
          end else if (last) begin
            load_c     = 1'b1;
            load_val_c = CNT_W'(RESET_CYCLES - 1);
          end else if (accept_c) begin
            load_c     = 1'b1;
            load_val_c = high_len(in_grb[MSB]);
          end
        end
      end
      default: ;
    endcase
  end

  ws2812_bit_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load_c),
    .load_val(load_val_c),
    .done_c  (tmr_done_c),
    .near_c  (tmr_near_c)
  );

  // in_ready and frame_done are set one cycle early so they are registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sr         <= '0;
      bit_idx    <= '0;
      last       <= 1'b0;
      dout       <= ~ACTIVE_LVL;
      in_ready   <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept_c) begin
            sr       <= in_grb;
            last     <= in_last;
            bit_idx  <= IDX_W'(MSB);
            state    <= HIGH;
            dout     <= ACTIVE_LVL;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        HIGH: begin
          if (tmr_done_c) begin
            state    <= LOW;
            dout     <= ~ACTIVE_LVL;
            in_ready <= (bit_idx == '0) && !last && (low_len(sr[MSB]) == '0);
          end
        end
        LOW: begin
          if (!tmr_done_c) begin
            in_ready <= (bit_idx == '0) && !last && tmr_near_c;
          end else if (bit_idx != '0) begin
            sr       <= {sr[MSB-1:0], 1'b0};
            bit_idx  <= bit_idx - IDX_W'(1);
            state    <= HIGH;
            dout     <= ACTIVE_LVL;
            in_ready <= 1'b0;
          end else if (last) begin
            state    <= LATCH;
            in_ready <= 1'b0;
            if (RESET_CYCLES == 1) frame_done <= 1'b1;
          end else if (accept_c) begin
            sr       <= in_grb;
            last     <= in_last;
            bit_idx  <= IDX_W'(MSB);
            state    <= HIGH;
            dout     <= ACTIVE_LVL;
            in_ready <= 1'b0;
          end else begin
            state    <= IDLE;
            in_ready <= 1'b1;
            busy     <= 1'b0;
          end
        end
        LATCH: begin
          if (tmr_done_c) begin
            state    <= IDLE;
            in_ready <= 1'b1;
            busy     <= 1'b0;
          end else if (tmr_near_c) begin
            frame_done <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ws2812_serializer.sv
// Scoreboard bench for ws2812_serializer; honours WS2812_INVERT_EN for line polarity.
module tb_ws2812_serializer;
  import ws2812_pkg::*;

  localparam int T0H = 5;
  localparam int T0L = 10;
  localparam int T1H = 10;
  localparam int T1L = 5;
  localparam int WORD_CYC  = 360;
  localparam int LATCH_CYC = 3600;
  localparam int BOUND     = 5000;

`ifdef WS2812_INVERT_EN
  localparam logic ACT = 1'b0;
`else
  localparam logic ACT = 1'b1;
`endif
  localparam logic IDL = ~ACT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [23:0] in_grb = '0;
  logic        in_last = 1'b0;
  logic        dout;
  logic        busy;
  logic        frame_done;

  ws2812_serializer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_grb    (in_grb),
    .in_last   (in_last),
    .dout      (dout),
    .busy      (busy),
    .frame_done(frame_done)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic b;
    int   start;
  } exp_bit_t;

  exp_bit_t    sb[$];
  exp_bit_t    e;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  int          n_fd = 0;
  int          fd_cyc = -1;
  int          n_acc = 0;
  int          last_acc = -1;
  int          prev_acc = -1;
  logic        prev_dout = 1'b0;
  logic        in_bit = 1'b0;
  int          pos, good, cur_h, cur_l, t;
  logic [23:0] w;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compares each pulse against the queue, then records new accepts
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      in_bit = 1'b0;
    end else begin
      if (in_bit) begin
        pos++;
        if (dout === ((pos < cur_h) ? ACT : IDL)) good++;
        if (pos == cur_h + cur_l - 1) begin
          check("bit_shape", good, cur_h + cur_l);
          in_bit = 1'b0;
        end
      end else if (dout === ACT && prev_dout !== ACT) begin
        if (sb.size() == 0) begin
          check("spurious_pulse", int'(dout), int'(IDL));
        end else begin
          e = sb.pop_front();
          check("bit_start", cyc, e.start);
          cur_h  = e.b ? T1H : T0H;
          cur_l  = e.b ? T1L : T0L;
          pos    = 0;
          good   = 1;
          in_bit = 1'b1;
        end
      end else if (dout !== IDL) begin
        check("line_level", int'(dout), int'(IDL));
      end
      if (frame_done === 1'b1) begin
        n_fd++;
        fd_cyc = cyc;
      end
      if (in_valid && in_ready) begin
        w = in_grb;
        t = cyc + 1;
        for (int i = 23; i >= 0; i--) begin
          sb.push_back('{b: w[i], start: t});
          t += w[i] ? (T1H + T1L) : (T0H + T0L);
        end
        prev_acc = last_acc;
        last_acc = cyc;
        n_acc++;
      end
    end
    prev_dout = dout;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [23:0] grb, input logic lst);
    int waited = 0;
    in_valid = 1'b1;
    in_grb   = grb;
    in_last  = lst;
    while (in_ready !== 1'b1 && waited < BOUND) begin
      tick(1);
      waited++;
    end
    if (waited >= BOUND) check("accept_timeout", waited, 0);
    tick(1);
  endtask

  task automatic wait_fd(input int base);
    int n = 0;
    while (n_fd == base && n < BOUND) begin
      tick(1);
      n++;
    end
    if (n_fd == base) check("frame_done_timeout", n_fd, base + 1);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ready"}, int'(in_ready), 1);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_dout"}, int'(dout), int'(IDL));
    check({tag, "_sb_empty"}, sb.size(), 0);
  endtask

  int a, base, acc0;

  initial begin
    tick(3);
    check("rst_dout", int'(dout), int'(IDL));
    check("rst_ready", int'(in_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_frame_done", int'(frame_done), 0);
    rst_n = 1'b1;

    // Stray in_last with no valid must be ignored
    in_last = 1'b1;
    tick(4);
    check("last_no_valid_busy", int'(busy), 0);

    // Single word, then underrun back to IDLE
    offer(24'h800000, 1'b0);
    in_valid = 1'b0;
    check("word_busy", int'(busy), 1);
    check("word_ready_low", int'(in_ready), 0);
    tick(WORD_CYC);
    check_idle("underrun");
    check("underrun_no_fd", n_fd, 0);

    // Back-to-back words with valid held high
    offer(24'hFFFFFF, 1'b0);
    offer(24'h000000, 1'b0);
    in_valid = 1'b0;
    check("b2b_accept_gap", last_acc - prev_acc, WORD_CYC);
    tick(WORD_CYC);
    check_idle("b2b");

    // Last pixel of a frame: latch interval then frame_done
    base = n_fd;
    offer(24'h00FF00, 1'b1);
    in_valid = 1'b0;
    a = last_acc;
    wait_fd(base);
    check("fd_cycle", fd_cyc, a + WORD_CYC + LATCH_CYC);
    check("fd_width", int'(frame_done), 0);
    check("fd_count", n_fd, base + 1);
    check_idle("after_fd");

    // Valid held through LATCH is not consumed until IDLE
    base = n_fd;
    offer(24'h123456, 1'b1);
    acc0     = n_acc;
    in_grb   = 24'hAAAAAA;
    in_last  = 1'b0;
    wait_fd(base);
    in_grb = 24'h5A5A5A;
    tick(1);
    in_valid = 1'b0;
    check("held_accept_count", n_acc, acc0 + 1);
    check("held_accept_cycle", last_acc, fd_cyc + 1);
    tick(WORD_CYC);
    check_idle("held");

    // Reset mid-word while dout is high
    base = n_fd;
    offer(24'hC3C3C3, 1'b1);
    in_valid = 1'b0;
    tick(99);
    check("pre_rst_dout", int'(dout), int'(ACT));
    rst_n = 1'b0;
    #1;
    check("mid_rst_dout", int'(dout), int'(IDL));
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_ready", int'(in_ready), 1);
    check("mid_rst_fd", int'(frame_done), 0);
    tick(2);
    rst_n = 1'b1;
    tick(LATCH_CYC + 400);
    check("rst_no_fd", n_fd, base);
    offer(24'h0F0F0F, 1'b0);
    in_valid = 1'b0;
    tick(WORD_CYC);
    check_idle("post_rst");
    check("ws_g_field", int'(last_acc > 0), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
